// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial-bit in/out bundle for the sequence detector
interface seq_detect_param_if #(
   parameter int N     = 5,
   parameter int CNT_W = 8
);
   logic                 en;
   logic                 in;
   logic                 clr_cnt;
   logic                 match;
   logic                 match_q;
   logic [$clog2(N)-1:0] state;
   logic [CNT_W-1:0]     match_cnt;
   modport master (output en, in, clr_cnt, input match, match_q, state, match_cnt);
   modport slave  (input en, in, clr_cnt, output match, match_q, state, match_cnt);
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: KMP serial pattern detector with Mealy match output.
// Define SEQ_DETECT_CNT_EN to include the saturating match counter.
module seq_detect_param #(
   parameter int             N       = 5,
   parameter logic [N-1:0]   PATTERN = 5'b10011,
   parameter bit             OVERLAP = 1,
   parameter int             CNT_W   = 8
) (
   input logic               clk,
   input logic               rst,
   seq_detect_param_if.slave b
);
   localparam int SW = $clog2(N);
   // longest prefix that is a suffix of (first k pattern bits, then bit_in), excluding a full match
   function automatic int kmp(int k, logic bit_in);
      int  best;
      int  i;
      logic ok;
      best = 0;
      for (int j = 1; j <= N - 1; j++) begin
         if (j <= k + 1) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
               i = k + 1 - j + t;
               if (((i == k) ? bit_in : PATTERN[N-1-i]) != PATTERN[N-1-t]) ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction
   function automatic int border();
      int  best;
      logic ok;
      best = 0;
      for (int j = 1; j <= N - 1; j++) begin
         ok = 1'b1;
         for (int t = 0; t < j; t++)
            if (PATTERN[N-1-t] != PATTERN[j-1-t]) ok = 1'b0;
         if (ok) best = j;
      end
      return best;
   endfunction
   localparam logic [SW-1:0] FB = OVERLAP ? SW'(border()) : '0;
   logic [SW-1:0] t0 [N];
   logic [SW-1:0] t1 [N];
   logic [SW-1:0] st;
   logic [SW-1:0] nxt;
   logic          valid;
   logic          hit;
   logic          hit_q;
   genvar k;
   for (k = 0; k < N; k++) begin : g_tab
      assign t0[k] = SW'(kmp(k, 1'b0));
      assign t1[k] = SW'(kmp(k, 1'b1));
   end
   always_comb begin
      valid = 32'(st) < N;
      hit   = !rst && valid && b.en && st == SW'(N - 1) && b.in == PATTERN[0];
      nxt   = !valid ? '0 : !b.en ? st : hit ? FB : b.in ? t1[st] : t0[st];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st    <= '0;
         hit_q <= 1'b0;
      end else begin
         st    <= nxt;
         hit_q <= hit;
      end
   end
   assign b.state   = st;
   assign b.match   = hit;
   assign b.match_q = hit_q;
`ifdef SEQ_DETECT_CNT_EN
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (b.clr_cnt) cnt <= '0;
      else if (hit && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign b.match_cnt = cnt;
`else
   logic unused_clr;
   assign unused_clr  = b.clr_cnt;
   assign b.match_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and random checks of four detector configurations
// against a bit-history reference model.
module tb_seq_detect_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   seq_detect_param_if #(.N(5), .CNT_W(8)) i0 ();
   seq_detect_param_if #(.N(4), .CNT_W(8)) i1 ();
   seq_detect_param_if #(.N(4), .CNT_W(8)) i2 ();
   seq_detect_param_if #(.N(5), .CNT_W(2)) i3 ();
   seq_detect_param #(.N(5), .PATTERN(5'b10011), .OVERLAP(1), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .b(i0));
   seq_detect_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .b(i1));
   seq_detect_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .b(i2));
   seq_detect_param #(.N(5), .PATTERN(5'b10011), .OVERLAP(1), .CNT_W(2)) u3 (.clk(clk), .rst(rst), .b(i3));
   logic        en_v [4];
   logic        in_v [4];
   logic        clr_v [4];
   logic [31:0] om [4];
   logic [31:0] oq [4];
   logic [31:0] os [4];
   logic [31:0] oc [4];
   assign i0.en = en_v[0]; assign i0.in = in_v[0]; assign i0.clr_cnt = clr_v[0];
   assign i1.en = en_v[1]; assign i1.in = in_v[1]; assign i1.clr_cnt = clr_v[1];
   assign i2.en = en_v[2]; assign i2.in = in_v[2]; assign i2.clr_cnt = clr_v[2];
   assign i3.en = en_v[3]; assign i3.in = in_v[3]; assign i3.clr_cnt = clr_v[3];
   assign om[0] = 32'(i0.match); assign oq[0] = 32'(i0.match_q); assign os[0] = 32'(i0.state); assign oc[0] = 32'(i0.match_cnt);
   assign om[1] = 32'(i1.match); assign oq[1] = 32'(i1.match_q); assign os[1] = 32'(i1.state); assign oc[1] = 32'(i1.match_cnt);
   assign om[2] = 32'(i2.match); assign oq[2] = 32'(i2.match_q); assign os[2] = 32'(i2.state); assign oc[2] = 32'(i2.match_cnt);
   assign om[3] = 32'(i3.match); assign oq[3] = 32'(i3.match_q); assign os[3] = 32'(i3.state); assign oc[3] = 32'(i3.match_cnt);
   // reference model: history of accepted bits (newest in bit 0) since reset or last non-overlap match
   int          mn  [4] = '{5, 4, 4, 5};
   logic [15:0] mp  [4] = '{16'h13, 16'hB, 16'hB, 16'h13};
   bit          mov [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   int          mw  [4] = '{8, 8, 8, 2};
   logic [63:0] mh  [4];
   int          mhl [4];
   int          mc  [4];
   int          n_chk  = 0;
   int          n_fail = 0;
   bit          obs_m;
   function automatic logic [63:0] mask(int k);
      return (64'd1 << k) - 64'd1;
   endfunction
   function automatic bit exp_match(int d, bit b);
      logic [63:0] h;
      h = {mh[d][62:0], b};
      return (mhl[d] + 1 >= mn[d]) && ((h & mask(mn[d])) == 64'(mp[d]));
   endfunction
   function automatic int exp_state(int d);
      for (int k = mn[d] - 1; k >= 1; k--)
         if (mhl[d] >= k && (mh[d] & mask(k)) == 64'(mp[d] >> (mn[d] - k))) return k;
      return 0;
   endfunction
   function automatic void clear_models();
      for (int i = 0; i < 4; i++) begin
         mh[i]  = '0;
         mhl[i] = 0;
         mc[i]  = 0;
      end
   endfunction
   task automatic check(string tag, int d, logic [31:0] obs, logic [31:0] ex);
      n_chk++;
      assert (obs === ex) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, ex);
      end
   endtask
   task automatic step(int d, bit e, bit b, bit c);
      bit m;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         en_v[i]  = 1'b0;
         in_v[i]  = 1'($urandom_range(0, 1));
         clr_v[i] = 1'b0;
      end
      en_v[d] = e; in_v[d] = b; clr_v[d] = c;
      #1;
      m = e && exp_match(d, b);
      obs_m = om[d][0];
      check("match", d, om[d], 32'(m));
      @(posedge clk);
      #1;
      if (e) begin
         mh[d] = {mh[d][62:0], b};
         mhl[d]++;
         if (m && !mov[d]) mhl[d] = 0;
      end
`ifdef SEQ_DETECT_CNT_EN
      if (c) mc[d] = 0;
      else if (m && mc[d] < (1 << mw[d]) - 1) mc[d]++;
`endif
      check("state", d, os[d], 32'(exp_state(d)));
      check("match_q", d, oq[d], 32'(m));
      check("match_cnt", d, oc[d], 32'(mc[d]));
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      clear_models();
      for (int i = 0; i < 4; i++) begin
         check("rst_state", i, os[i], 0);
         check("rst_match", i, om[i], 0);
         check("rst_match_q", i, oq[i], 0);
         check("rst_cnt", i, oc[i], 0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask
   int s30 [9] = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
   int s31 [7] = '{1, 0, 1, 1, 0, 1, 1};
   int s35 [6] = '{1, 1, 0, 0, 1, 1};
   initial begin
      logic [31:0] mk1, mk2;
      int exp_cnt [5];
      for (int i = 0; i < 4; i++) begin
         en_v[i] = 1'b0; in_v[i] = 1'b0; clr_v[i] = 1'b0;
      end
      clear_models();
      do_reset();
      // default pattern, overlapping stream
      mk1 = 0;
      for (int i = 0; i < 9; i++) begin
         step(0, 1'b1, s30[i][0], 1'b0);
         if (obs_m) mk1[i] = 1'b1;
      end
      check("c30_mask", 0, mk1, 32'h110);
      // 1011 with and without overlap
      mk1 = 0; mk2 = 0;
      for (int i = 0; i < 7; i++) begin
         step(1, 1'b1, s31[i][0], 1'b0);
         if (obs_m) mk1[i] = 1'b1;
         step(2, 1'b1, s31[i][0], 1'b0);
         if (obs_m) mk2[i] = 1'b1;
      end
      check("c31_ov_mask", 1, mk1, 32'h48);
      check("c31_nov_mask", 2, mk2, 32'h08);
      // stall with in toggling
      do_reset();
      step(0, 1'b1, 1'b1, 1'b0); step(0, 1'b1, 1'b0, 1'b0); step(0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1'b0, i[0] ? 1'b0 : 1'b1, 1'b0);
         check("c32_hold", 0, os[0], 3);
      end
      step(0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1, 1'b0);
      check("c32_match", 0, 32'(obs_m), 1);
      // asynchronous reset mid-pattern
      do_reset();
      step(0, 1'b1, 1'b1, 1'b0); step(0, 1'b1, 1'b0, 1'b0); step(0, 1'b1, 1'b0, 1'b0); step(0, 1'b1, 1'b1, 1'b0);
      check("c33_pre", 0, os[0], 4);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      clear_models();
      check("c33_async_state", 0, os[0], 0);
      check("c33_async_match", 0, om[0], 0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 1'b1, 1'b1, 1'b0);
      check("c33_nomatch", 0, 32'(obs_m), 0);
      check("c33_state", 0, os[0], 1);
      // KMP fallback
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(0, 1'b1, s35[i][0], 1'b0);
         if (i == 1) check("c35_fallback", 0, os[0], 1);
      end
      check("c35_match", 0, 32'(obs_m), 1);
      // saturating counter, CNT_W=2
      do_reset();
`ifdef SEQ_DETECT_CNT_EN
      exp_cnt = '{1, 2, 3, 3, 3};
`else
      exp_cnt = '{0, 0, 0, 0, 0};
`endif
      step(3, 1'b1, 1'b1, 1'b0); step(3, 1'b1, 1'b0, 1'b0); step(3, 1'b1, 1'b0, 1'b0); step(3, 1'b1, 1'b1, 1'b0);
      step(3, 1'b1, 1'b1, 1'b0);
      check("c34_cnt", 3, oc[3], 32'(exp_cnt[0]));
      for (int m = 1; m < 5; m++) begin
         step(3, 1'b1, 1'b0, 1'b0); step(3, 1'b1, 1'b0, 1'b0); step(3, 1'b1, 1'b1, 1'b0); step(3, 1'b1, 1'b1, 1'b0);
         check("c34_cnt", 3, oc[3], 32'(exp_cnt[m]));
      end
      step(3, 1'b1, 1'b0, 1'b0); step(3, 1'b1, 1'b0, 1'b0); step(3, 1'b1, 1'b1, 1'b0); step(3, 1'b1, 1'b1, 1'b1);
      check("c34_clr_match", 3, 32'(obs_m), 1);
      check("c34_clr", 3, oc[3], 0);
      // random streams
      for (int d = 0; d < 4; d++) begin
         do_reset();
         for (int i = 0; i < 300; i++)
            step(d, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter N, default 5, meaning pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 5'b10011, meaning the N-bit target; PATTERN[N-1] is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed and 0 = non-overlapping.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning the match counter width.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-high.
REQ-007 The block SHALL have port en, input, 1 bit, meaning in carries a valid serial bit this cycle.
REQ-008 The block SHALL have port in, input, 1 bit, meaning the serial data bit.
REQ-009 The block SHALL have port clr_cnt, input, 1 bit, meaning synchronous clear of match_cnt.
REQ-010 The block SHALL have port match, output, 1 bit, meaning the Mealy match indication, combinational from state, en and in.
REQ-011 The block SHALL have port match_q, output, 1 bit, meaning match registered, one cycle later.
REQ-012 The block SHALL have port state, output, clog2(N) bits, meaning the number of pattern bits currently matched (0..N-1).
REQ-013 The block SHALL have port match_cnt, output, CNT_W bits, meaning the saturating count of matches.

Function
REQ-014 State k SHALL mean that the last k accepted bits equal PATTERN[N-1:N-k]; legal states are 0..N-1.
REQ-015 With en=0, the block SHALL hold state, match_cnt and all internal registers; match SHALL be 0 and match_q SHALL load 0.
REQ-016 With en=1 and no full match, next state SHALL be the longest prefix of PATTERN that is a proper suffix of (matched prefix followed by in), i.e. a KMP transition; it SHALL never fall back to 0 when a shorter prefix still matches.
REQ-017 match SHALL be 1 iff en=1, state=N-1 and in=PATTERN[0]; there SHALL be zero-cycle latency from the final bit.
REQ-018 On a match with OVERLAP=1, next state SHALL be the longest proper prefix of PATTERN that is also a suffix of PATTERN.
REQ-019 On a match with OVERLAP=0, next state SHALL be 0.
REQ-020 The transition and failure values SHALL be derived from parameters at elaboration, with no runtime tables or configuration registers.
REQ-021 match_q SHALL equal match delayed by exactly one clk.
REQ-022 The state encoding SHALL be binary; any unreachable encoding SHALL transition to 0 on the next edge regardless of en.

Reset
REQ-023 rst=1 SHALL force state=0, match_q=0 and match_cnt=0 asynchronously; match SHALL be 0 while rst=1.
REQ-024 Reset mid-pattern SHALL discard all partial progress; bits accepted before reset SHALL never contribute to a later match.
REQ-025 The first edge after rst deasserts SHALL process in normally if en=1.

Configuration
REQ-026 Macro SEQ_DETECT_CNT_EN SHALL control inclusion of the match counter.
REQ-027 With SEQ_DETECT_CNT_EN defined, match_cnt SHALL increment on each clock where match=1 and SHALL saturate at 2^CNT_W-1.
REQ-028 With SEQ_DETECT_CNT_EN defined, clr_cnt=1 SHALL load 0 on the next edge, and SHALL take priority over a simultaneous increment.
REQ-029 Without SEQ_DETECT_CNT_EN, match_cnt SHALL be tied to 0, clr_cnt SHALL be ignored, and no counter flops SHALL be inferred; all other behaviour is unchanged.

Verification
REQ-030 The bench SHALL cover: defaults, en=1, stream 1,0,0,1,1,0,0,1,1 -> match=1 on bits 5 and 9 only, and match_q=1 on the following cycles.
REQ-031 The bench SHALL cover: N=4, PATTERN=1011, stream 1,0,1,1,0,1,1 -> OVERLAP=1 matches on bits 4 and 7; OVERLAP=0 matches on bit 4 only.
REQ-032 The bench SHALL cover: defaults, stream 1,0,0 then en=0 for 3 cycles with in toggling, then 1,1 -> state held at 3 during the stall, match=1 on the final bit.
REQ-033 The bench SHALL cover: defaults, stream 1,0,0,1, then rst pulsed mid-cycle, then 1 -> state=0 immediately on rst, no match, state=1 after the final bit.
REQ-034 The bench SHALL cover: SEQ_DETECT_CNT_EN defined, CNT_W=2, 5 matches -> match_cnt reads 1,2,3,3,3; clr_cnt asserted on a match cycle -> match_cnt=0.
REQ-035 The bench SHALL cover: defaults, stream 1,1,0,0,1,1 -> KMP fallback keeps state=1 after the second 1, match=1 on the final bit.
